// File: rtl/display_scan_driver_if.sv
// Handshake and scan bundle between the reaction-timer side and the display scan driver.
// The slave modport is the driver itself; the master modport is whoever loads values and watches the scan.
interface display_scan_driver_if;
  logic [12:0] timeToDisplay;
  logic        load;
  logic        busy;
  logic        valid;
  logic [3:0]  digits;
  logic [3:0]  bcdDigit;
  logic        blankDigit;

  modport master (
    output timeToDisplay,
    output load,
    input  busy,
    input  valid,
    input  digits,
    input  bcdDigit,
    input  blankDigit
  );

  modport slave (
    input  timeToDisplay,
    input  load,
    output busy,
    output valid,
    output digits,
    output bcdDigit,
    output blankDigit
  );
endinterface

// File: rtl/display_scan_driver.sv
// Binary-to-BCD (sequential double dabble) plus one-hot four-digit scan for a seven-segment display.
// Define LEAD_ZERO_BLANK_EN for full leading-zero blanking; otherwise only a zero thousands digit is blanked.
module display_scan_driver #(
  parameter int REFRESH_COUNT = 100000,
  parameter int CNT_WIDTH     = $clog2(REFRESH_COUNT)
) (
  input  logic                  clk,
  input  logic                  resetN,
  display_scan_driver_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  localparam logic [3:0]           LAST_ITER = 4'd12;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(REFRESH_COUNT - 1);

  logic [1:0]           state_q, state_d;
  logic [12:0]          bin_q, bin_d;
  logic [15:0]          scratch_q, scratch_d;
  logic [3:0]           iter_q, iter_d;
  logic [15:0]          committed_q, committed_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] refreshCnt_q, refreshCnt_d;
  logic [3:0]           digits_q, digits_d;
  logic [3:0]           bcdDigit_q, bcdDigit_d;
  logic                 blankDigit_q, blankDigit_d;

  logic [15:0] scratchAdj;
  logic [28:0] shifted;
  logic        tick;
  logic [3:0]  digitsNext;
  logic [3:0]  thousandsNib, hundredsNib, tensNib, onesNib;
  logic        blankNext;

  function automatic logic [15:0] addThree(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  assign scratchAdj = addThree(scratch_q);
  assign shifted    = {scratchAdj[14:0], bin_q, 1'b0};

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    scratch_d   = scratch_q;
    iter_d      = iter_q;
    committed_d = committed_q;
    valid_d     = 1'b0;
    busy_d      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          bin_d     = bus.timeToDisplay;
          scratch_d = 16'h0000;
          iter_d    = 4'd0;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        scratch_d = shifted[28:13];
        bin_d     = shifted[12:0];
        iter_d    = iter_q + 4'd1;
        if (iter_q == LAST_ITER) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        committed_d = scratch_q;
        valid_d     = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The scan samples committed_d so a commit landing on a tick is shown immediately.
  assign thousandsNib = committed_d[15:12];
  assign hundredsNib  = committed_d[11:8];
  assign tensNib      = committed_d[7:4];
  assign onesNib      = committed_d[3:0];

  assign tick = (refreshCnt_q == CNT_LAST);

  always_comb begin
    case (digits_q)
      4'b0001: digitsNext = 4'b0010;
      4'b0010: digitsNext = 4'b0100;
      4'b0100: digitsNext = 4'b1000;
      default: digitsNext = 4'b0001;
    endcase
  end

  always_comb begin
    blankNext = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
    case (digitsNext)
      4'b1000: blankNext = (thousandsNib == 4'd0);
      4'b0100: blankNext = (thousandsNib == 4'd0) && (hundredsNib == 4'd0);
      4'b0010: blankNext = (thousandsNib == 4'd0) && (hundredsNib == 4'd0) && (tensNib == 4'd0);
      default: blankNext = 1'b0;
    endcase
`else
    blankNext = (digitsNext == 4'b1000) && (thousandsNib == 4'd0);
`endif
  end

  always_comb begin
    refreshCnt_d = tick ? '0 : refreshCnt_q + CNT_WIDTH'(1);
    digits_d     = digits_q;
    bcdDigit_d   = bcdDigit_q;
    blankDigit_d = blankDigit_q;
    if (tick) begin
      digits_d     = digitsNext;
      blankDigit_d = blankNext;
      case (digitsNext)
        4'b0001: bcdDigit_d = onesNib;
        4'b0010: bcdDigit_d = tensNib;
        4'b0100: bcdDigit_d = hundredsNib;
        default: bcdDigit_d = thousandsNib;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      bin_q        <= '0;
      scratch_q    <= '0;
      iter_q       <= '0;
      committed_q  <= 16'h0000;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      refreshCnt_q <= '0;
      digits_q     <= 4'b0000;
      bcdDigit_q   <= 4'd0;
      blankDigit_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      scratch_q    <= scratch_d;
      iter_q       <= iter_d;
      committed_q  <= committed_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      refreshCnt_q <= refreshCnt_d;
      digits_q     <= digits_d;
      bcdDigit_q   <= bcdDigit_d;
      blankDigit_q <= blankDigit_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.valid      = valid_q;
  assign bus.digits     = digits_q;
  assign bus.bcdDigit   = bcdDigit_q;
  assign bus.blankDigit = blankDigit_q;

endmodule
